// File: rtl/inst_sram_like_axi_rd.sv
// inst_sram_like_axi_rd: sram-like instruction fetch responder issuing single-beat AXI reads
module inst_sram_like_axi_rd #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int ARID_VAL = 0,
  parameter int CNT_W = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_sram_req,
  input  logic [31:0] inst_sram_addr,
  output logic        inst_sram_addr_ok,
  output logic [31:0] inst_sram_rdata,
  output logic        inst_sram_data_ok,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic        rd_err
);
  logic [CNT_W-1:0] cnt;
  logic r_hs, ar_hs, r_take;
  logic unused;
  assign unused = ^{rid, rlast};
  assign r_hs = rvalid && rready;
  assign ar_hs = arvalid && arready;
  assign r_take = r_hs && (cnt != '0);
  assign inst_sram_addr_ok = inst_sram_req && (!arvalid || arready) &&
                             ((cnt < CNT_W'(MAX_OUTSTANDING)) || r_hs);
  assign arid = 4'(ARID_VAL);
  assign arlen = 8'd0;
  assign arsize = 3'b010;
  assign arburst = 2'b01;
  assign arlock = 2'b00;
  assign arcache = 4'd0;
  assign arprot = 3'd0;
  // AR slot: a new accept reloads it even while the previous address handshakes
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      arvalid <= 1'b0;
      araddr <= '0;
    end else if (inst_sram_addr_ok) begin
      arvalid <= 1'b1;
      araddr <= {inst_sram_addr[31:2], 2'b00};
    end else if (ar_hs) arvalid <= 1'b0;
  // outstanding requests: accepted but not yet answered; stray beats at zero are ignored
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else cnt <= cnt + CNT_W'(inst_sram_addr_ok) - CNT_W'(r_take);
  // return path: one data_ok pulse per answered request, rdata held afterwards
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      inst_sram_data_ok <= 1'b0;
      inst_sram_rdata <= '0;
    end else begin
      inst_sram_data_ok <= r_take;
      if (r_take) inst_sram_rdata <= rdata;
    end
  // sticky error flag and rready, which rises once reset is released
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rd_err <= 1'b0;
      rready <= 1'b0;
    end else begin
      rready <= 1'b1;
      if (r_hs && rresp != 2'b00) rd_err <= 1'b1;
    end
endmodule

// File: tb/tb_inst_sram_like_axi_rd.sv
// tb_inst_sram_like_axi_rd: directed and randomized checks against a queue-based reference model
module tb_inst_sram_like_axi_rd;
  localparam int MAX = 4;
  localparam logic [31:0] K = 32'h5A5A_F00F;
  logic clk = 0, reset = 1, req = 0, arready = 0, rvalid = 0;
  logic [31:0] addr = 0, r_data = 0;
  logic [1:0] rresp = 0;
  logic addr_ok, data_ok, arvalid, rready, rd_err;
  logic [31:0] sram_rdata, araddr;
  logic [3:0] arid, arcache;
  logic [7:0] arlen;
  logic [2:0] arsize, arprot;
  logic [1:0] arburst, arlock;
  int checks = 0, errors = 0;
  logic [31:0] m_arq[$], m_req_q[$], s_q[$];
  int m_out = 0;
  logic [31:0] m_araddr = 0, m_word = 0;
  bit m_dok = 0, m_err = 0, m_rready = 0;

  inst_sram_like_axi_rd #(.MAX_OUTSTANDING(MAX), .ARID_VAL(0), .CNT_W(3)) dut (
    .clk(clk), .reset(reset), .inst_sram_req(req), .inst_sram_addr(addr),
    .inst_sram_addr_ok(addr_ok), .inst_sram_rdata(sram_rdata), .inst_sram_data_ok(data_ok),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(4'd0), .rdata(r_data), .rresp(rresp), .rlast(1'b1), .rvalid(rvalid),
    .rready(rready), .rd_err(rd_err));

  always #5 clk = ~clk;

  function automatic bit exp_addr_ok();
    return req && (m_arq.size() == 0 || arready) && (m_out < MAX || (rvalid && m_rready));
  endfunction

  task automatic model_reset();
    m_arq.delete(); m_req_q.delete(); s_q.delete();
    m_out = 0; m_araddr = 0; m_dok = 0; m_err = 0; m_rready = 0;
  endtask

  task automatic tick();
    bit acc, hs, rb;
    logic [31:0] a;
    acc = exp_addr_ok();
    hs = m_arq.size() != 0 && arready;
    rb = rvalid && m_rready && m_out > 0;
    a = {addr[31:2], 2'b00};
    @(posedge clk);
    if (hs) void'(m_arq.pop_front());
    if (rb) m_word = m_req_q.pop_front() ^ K;
    if (acc) begin m_arq.push_back(a); m_req_q.push_back(a); m_araddr = a; end
    m_out = m_out + int'(acc) - int'(rb);
    m_dok = rb;
    if (rvalid && m_rready && rresp != 2'b00) m_err = 1;
    m_rready = 1;
    #1;
  endtask

  task automatic test_reset();
    reset = 1; req = 0; arready = 0; rvalid = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if ({arvalid, araddr, data_ok, sram_rdata, rd_err, rready} !== 67'd0) begin errors++; $display("FAIL reset_state got %h want 0", {arvalid, araddr, data_ok, sram_rdata, rd_err, rready}); end
    checks++; if ({arid, arlen, arsize, arburst, arlock, arcache, arprot} !== {4'd0, 8'd0, 3'b010, 2'b01, 2'b00, 4'd0, 3'd0}) begin errors++; $display("FAIL ar_consts got %h", {arid, arlen, arsize, arburst, arlock, arcache, arprot}); end
    reset = 0; model_reset();
    tick();
    checks++; if (rready !== 1'b1) begin errors++; $display("FAIL rready_after_reset got %b want 1", rready); end
  endtask

  task automatic test_single();
    req = 1; addr = 32'hBFC0_0000; arready = 1; rvalid = 0;
    #1;
    checks++; if (addr_ok !== 1'b1 || exp_addr_ok() !== 1'b1) begin errors++; $display("FAIL single_addr_ok got %b want 1", addr_ok); end
    tick(); req = 0;
    checks++; if (arvalid !== 1'b1 || araddr !== 32'hBFC0_0000) begin errors++; $display("FAIL single_ar got %b %h want 1 bfc00000", arvalid, araddr); end
    tick(); rvalid = 1; r_data = 32'h2402_0001;
    checks++; if (arvalid !== 1'b0 || data_ok !== 1'b0) begin errors++; $display("FAIL single_t2 got arvalid %b data_ok %b want 0 0", arvalid, data_ok); end
    tick(); rvalid = 0;
    checks++; if (data_ok !== 1'b1 || sram_rdata !== 32'h2402_0001) begin errors++; $display("FAIL single_data got %b %h want 1 24020001", data_ok, sram_rdata); end
    tick();
    checks++; if (data_ok !== 1'b0 || sram_rdata !== 32'h2402_0001) begin errors++; $display("FAIL single_hold got %b %h want 0 24020001", data_ok, sram_rdata); end
  endtask

  task automatic test_ar_stall();
    req = 1; addr = 32'hBFC0_0000; arready = 0;
    #1;
    checks++; if (addr_ok !== 1'b1) begin errors++; $display("FAIL stall_first_ok got %b want 1", addr_ok); end
    tick(); addr = 32'hBFC0_0004;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (addr_ok !== 1'b0 || arvalid !== 1'b1 || araddr !== 32'hBFC0_0000) begin errors++; $display("FAIL stall_hold cyc %0d got ok %b v %b a %h want 0 1 bfc00000", i, addr_ok, arvalid, araddr); end
      tick();
    end
    arready = 1; #1;
    checks++; if (addr_ok !== 1'b1) begin errors++; $display("FAIL stall_second_ok got %b want 1", addr_ok); end
    tick(); req = 0;
    checks++; if (arvalid !== 1'b1 || araddr !== 32'hBFC0_0004) begin errors++; $display("FAIL stall_reload got %b %h want 1 bfc00004", arvalid, araddr); end
    tick();
    checks++; if (arvalid !== 1'b0) begin errors++; $display("FAIL stall_drop got %b want 0", arvalid); end
    rvalid = 1; r_data = 32'h1; tick(); r_data = 32'h2; tick(); rvalid = 0;
    checks++; if (data_ok !== 1'b1 || sram_rdata !== 32'h2) begin errors++; $display("FAIL stall_data got %b %h want 1 2", data_ok, sram_rdata); end
    tick();
  endtask

  task automatic test_max_outstanding();
    int n = 0;
    for (int i = 0; i < 8; i++) begin
      req = 1; addr = 32'h1000 + 32'(i * 4); arready = 1; #1;
      if (addr_ok) n++;
      checks++; if (addr_ok !== exp_addr_ok()) begin errors++; $display("FAIL max_ok cyc %0d got %b want %b", i, addr_ok, exp_addr_ok()); end
      tick();
    end
    checks++; if (n != MAX) begin errors++; $display("FAIL max_count got %0d want %0d", n, MAX); end
    rvalid = 1; r_data = 32'hAA; #1;
    checks++; if (addr_ok !== 1'b1) begin errors++; $display("FAIL max_beat_ok got %b want 1", addr_ok); end
    tick(); rvalid = 0; #1;
    checks++; if (addr_ok !== 1'b0 || data_ok !== 1'b1 || sram_rdata !== 32'hAA) begin errors++; $display("FAIL max_full got ok %b dok %b d %h want 0 1 aa", addr_ok, data_ok, sram_rdata); end
    req = 0; tick();
  endtask

  task automatic test_burst_return();
    logic [31:0] vals[4] = '{32'h11, 32'h22, 32'h33, 32'h44};
    for (int i = 0; i < 4; i++) begin
      rvalid = 1; r_data = vals[i]; tick();
      checks++; if (data_ok !== 1'b1 || sram_rdata !== vals[i]) begin errors++; $display("FAIL burst_%0d got %b %h want 1 %h", i, data_ok, sram_rdata, vals[i]); end
    end
    rvalid = 0; tick();
    checks++; if (data_ok !== 1'b0 || sram_rdata !== 32'h44 || arvalid !== 1'b0) begin errors++; $display("FAIL burst_end got %b %h %b want 0 44 0", data_ok, sram_rdata, arvalid); end
  endtask

  task automatic test_error();
    req = 1; arready = 1; addr = 32'h2000; tick(); addr = 32'h2004; tick(); req = 0; tick();
    rvalid = 1; rresp = 2'b00; r_data = 32'h77; tick();
    checks++; if (rd_err !== 1'b0 || data_ok !== 1'b1) begin errors++; $display("FAIL err_first got err %b dok %b want 0 1", rd_err, data_ok); end
    rresp = 2'b10; r_data = 32'h88; tick(); rvalid = 0; rresp = 2'b00;
    checks++; if (rd_err !== 1'b1 || data_ok !== 1'b1 || sram_rdata !== 32'h88) begin errors++; $display("FAIL err_second got err %b dok %b d %h want 1 1 88", rd_err, data_ok, sram_rdata); end
    repeat (3) tick();
    checks++; if (rd_err !== 1'b1 || rd_err !== m_err) begin errors++; $display("FAIL err_sticky got %b want 1", rd_err); end
  endtask

  task automatic test_async_reset();
    int n = 0;
    req = 1; arready = 1; addr = 32'h3000; tick(); addr = 32'h3004; arready = 0; tick(); req = 0;
    checks++; if (arvalid !== 1'b1) begin errors++; $display("FAIL areset_setup got %b want 1", arvalid); end
    #2 reset = 1; #1;
    checks++; if (arvalid !== 1'b0 || data_ok !== 1'b0 || rready !== 1'b0 || rd_err !== 1'b0) begin errors++; $display("FAIL areset_immediate got v %b dok %b rr %b err %b want 0", arvalid, data_ok, rready, rd_err); end
    @(posedge clk); #1 reset = 0; model_reset();
    tick();
    for (int i = 0; i < 6; i++) begin
      req = 1; arready = 1; addr = 32'h4000 + 32'(i * 4); #1;
      if (addr_ok) n++;
      tick();
    end
    req = 0; tick();
    checks++; if (n != MAX) begin errors++; $display("FAIL areset_cnt_cleared accepts %0d want %0d", n, MAX); end
    rvalid = 1; repeat (4) tick(); rvalid = 0; tick();
    req = 1; addr = 32'hBFC0_0010; #1;
    checks++; if (addr_ok !== 1'b1) begin errors++; $display("FAIL areset_fresh_ok got %b want 1", addr_ok); end
    tick(); req = 0; tick(); rvalid = 1; r_data = 32'hCAFE_0001; tick(); rvalid = 0;
    checks++; if (data_ok !== 1'b1 || sram_rdata !== 32'hCAFE_0001) begin errors++; $display("FAIL areset_fresh_data got %b %h want 1 cafe0001", data_ok, sram_rdata); end
    tick();
  endtask

  task automatic test_random();
    bit beat;
    int k = 0;
    for (int i = 0; i < 400 || (k < 60 && (m_out > 0 || m_arq.size() > 0)); i++) begin
      if (i >= 400) k++;
      req = (i < 400) && ($urandom_range(0, 2) != 0);
      addr = $urandom;
      arready = (i >= 400) || ($urandom_range(0, 3) != 0);
      beat = s_q.size() > 0 && ((i >= 400) || $urandom_range(0, 2) != 0);
      rvalid = beat; r_data = beat ? (s_q[0] ^ K) : $urandom;
      #1;
      checks++; if (addr_ok !== exp_addr_ok()) begin errors++; $display("FAIL rand_ok cyc %0d got %b want %b", i, addr_ok, exp_addr_ok()); end
      if (arvalid && arready) s_q.push_back(araddr);
      tick();
      if (beat) void'(s_q.pop_front());
      checks++; if (arvalid !== (m_arq.size() > 0) || (arvalid && araddr !== m_araddr)) begin errors++; $display("FAIL rand_ar cyc %0d got %b %h want %b %h", i, arvalid, araddr, m_arq.size() > 0, m_araddr); end
      checks++; if (data_ok !== m_dok || (m_dok && sram_rdata !== m_word)) begin errors++; $display("FAIL rand_data cyc %0d got %b %h want %b %h", i, data_ok, sram_rdata, m_dok, m_word); end
    end
    rvalid = 0;
    checks++; if (m_out != 0 || s_q.size() != 0 || rd_err !== 1'b0) begin errors++; $display("FAIL rand_drain left %0d pending %0d err %b want 0 0 0", m_out, s_q.size(), rd_err); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_ar_stall();
    test_max_outstanding();
    test_burst_return();
    test_error();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
